// File: rtl/rom_dl_writer_pkg.sv
// Shared types and sizing helpers for the ROM download writer.
// Optional feature macro used by the top: DL_CSUM_EN (running byte checksum).
package rom_dl_writer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StWrite,
    StHold,
    StDone
  } dl_state_e;

  // One spare counter bit so the overflow limit is representable without wrapping.
  localparam int unsigned CntGuardBits = 1;

  function automatic int unsigned reg_log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned reg_idx_w(input int unsigned n);
    return (reg_log2(n) == 0) ? 1 : reg_log2(n);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned aw, input int unsigned nreg);
    return aw + reg_log2(nreg) + CntGuardBits;
  endfunction

  // Total writable bytes across all regions; an accept at this count is dropped.
  function automatic int unsigned ovf_limit(input int unsigned aw, input int unsigned nreg);
    return nreg << aw;
  endfunction

endpackage

// File: rtl/rom_dl_writer_if.sv
// Host byte stream plus ROM write port bundle; the writer uses the slave view.
interface rom_dl_writer_if #(
  parameter int unsigned AW   = 14,
  parameter int unsigned NREG = 4
) ();

  logic            s_valid;
  logic            s_ready;
  logic            s_last;
  logic [7:0]      s_data;
  logic [AW-1:0]   wr_adr;
  logic [7:0]      wr_dat;
  logic [NREG-1:0] wr_en;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, wr_adr, wr_dat, wr_en
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, wr_adr, wr_dat, wr_en
  );

endinterface

// File: rtl/rom_dl_writer_region_dec.sv
// Combinational split of the running byte count into region index, local address
// and an overflow flag.
module rom_dl_writer_region_dec
  import rom_dl_writer_pkg::*;
#(
  parameter int unsigned AW   = 14,
  parameter int unsigned NREG = 4
) (
  input  logic [cnt_w(AW, NREG)-1:0] i_cnt,
  output logic [reg_idx_w(NREG)-1:0] o_region,
  output logic [AW-1:0]              o_adr,
  output logic                       o_ovf
);

  localparam int unsigned LN = reg_log2(NREG);
  localparam int unsigned CW = cnt_w(AW, NREG);

  assign o_adr = i_cnt[AW-1:0];

  generate
    if (LN == 0) begin : g_single
      assign o_region = '0;
    end else begin : g_multi
      assign o_region = i_cnt[AW+LN-1:AW];
    end
  endgenerate

  assign o_ovf = (i_cnt == CW'(ovf_limit(AW, NREG)));

endmodule

// File: rtl/rom_dl_writer.sv
// Download writer: accepts host bytes, writes them to the decoded ROM region.
// Define DL_CSUM_EN to build the running 16-bit byte checksum on csum.
module rom_dl_writer
  import rom_dl_writer_pkg::*;
#(
  parameter int unsigned AW   = 14,
  parameter int unsigned NREG = 4,
  parameter int unsigned WS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  rom_dl_writer_if.slave       bus,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf,
  output logic [15:0]          csum
);

  localparam int unsigned CW       = cnt_w(AW, NREG);
  localparam int unsigned RW       = reg_idx_w(NREG);
  localparam logic [3:0]  HoldInit = 4'(WS - 1);

  dl_state_e       r_state;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_adr;
  logic [7:0]      r_dat;
  logic [NREG-1:0] r_en;
  logic [3:0]      r_hold;
  logic            r_last;
  logic            r_ready;
  logic            r_busy;
  logic            r_done;
  logic            r_ovf;

  logic [RW-1:0]   w_region;
  logic [AW-1:0]   w_adr;
  logic            w_ovf;
  logic            w_accept;

  rom_dl_writer_region_dec #(
    .AW   (AW),
    .NREG (NREG)
  ) u_region_dec (
    .i_cnt    (r_cnt),
    .o_region (w_region),
    .o_adr    (w_adr),
    .o_ovf    (w_ovf)
  );

  // s_ready is only ever high in RECV, so it alone qualifies the handshake.
  assign w_accept = r_ready & bus.s_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_en    <= '0;
      r_hold  <= '0;
      r_last  <= 1'b0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (start) begin
      r_state <= StRecv;
      r_cnt   <= '0;
      r_en    <= '0;
      r_last  <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        StRecv: begin
          if (w_accept) begin
            if (w_ovf) begin
              // Byte beyond the last region is dropped; cnt stays at the limit.
              r_ovf <= 1'b1;
              if (bus.s_last) begin
                r_state <= StDone;
                r_ready <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_adr   <= w_adr;
              r_dat   <= bus.s_data;
              r_en    <= NREG'(1) << w_region;
              r_last  <= bus.s_last;
              r_hold  <= HoldInit;
              r_ready <= 1'b0;
              r_state <= StWrite;
            end
          end
        end
        StWrite, StHold: begin
          if (r_hold == 4'd0) begin
            r_en  <= '0;
            r_cnt <= r_cnt + CW'(1);
            if (r_last) begin
              r_state <= StDone;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= StRecv;
              r_ready <= 1'b1;
            end
          end else begin
            r_hold  <= r_hold - 4'd1;
            r_state <= StHold;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.s_ready = r_ready;
  assign bus.wr_adr  = r_adr;
  assign bus.wr_dat  = r_dat;
  assign bus.wr_en   = r_en;
  assign busy        = r_busy;
  assign done        = r_done;
  assign ovf         = r_ovf;

`ifdef DL_CSUM_EN
  logic [15:0] r_csum;

  // Counts every accepted byte, including dropped overflow bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csum <= '0;
    end else if (start) begin
      r_csum <= '0;
    end else if (w_accept) begin
      r_csum <= r_csum + {8'h00, bus.s_data};
    end
  end

  assign csum = r_csum;
`else
  assign csum = '0;
`endif

endmodule

// File: tb/tb_rom_dl_writer.sv
// Directed bench: WS=1 and WS=3 writers (AW=4, NREG=2) driven through shared tasks.
module tb_rom_dl_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        busy_a, done_a, ovf_a;
  logic        busy_b, done_b, ovf_b;
  logic [15:0] csum_a, csum_b;

  int n_checks = 0;
  int n_errors = 0;

  rom_dl_writer_if #(.AW(4), .NREG(2)) ifa ();
  rom_dl_writer_if #(.AW(4), .NREG(2)) ifb ();

  rom_dl_writer #(.AW(4), .NREG(2), .WS(1)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_a),
    .bus   (ifa),
    .busy  (busy_a),
    .done  (done_a),
    .ovf   (ovf_a),
    .csum  (csum_a)
  );

  rom_dl_writer #(.AW(4), .NREG(2), .WS(3)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_b),
    .bus   (ifb),
    .busy  (busy_b),
    .done  (done_b),
    .ovf   (ovf_b),
    .csum  (csum_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic [7:0] d, input logic l, input logic v);
    if (sel) begin
      ifb.s_valid = v; ifb.s_data = d; ifb.s_last = l;
    end else begin
      ifa.s_valid = v; ifa.s_data = d; ifa.s_last = l;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? ifb.s_ready : ifa.s_ready;
  endfunction

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Returns 1 time unit after the accepting edge.
  task automatic send(input bit sel, input logic [7:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    drive(sel, d, l, 1'b1);
    while (!rdy(sel) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(rdy(sel)), 32'd1);
    @(posedge clk);
    #1;
    drive(sel, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] csum_exp;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ifa.s_ready), 32'd0);
    chk("rst_adr",   32'(ifa.wr_adr),  32'd0);
    chk("rst_dat",   32'(ifa.wr_dat),  32'd0);
    chk("rst_en",    32'(ifa.wr_en),   32'd0);
    chk("rst_busy",  32'(busy_a),      32'd0);
    chk("rst_done",  32'(done_a),      32'd0);
    chk("rst_ovf",   32'(ovf_a),       32'd0);
    chk("rst_csum",  32'(csum_a),      32'd0);
    rst_n = 1'b1;

    // 32 bytes fill both regions exactly.
    pulse_start(1'b0);
    chk("t1_busy",  32'(busy_a),      32'd1);
    chk("t1_ready", 32'(ifa.s_ready), 32'd1);
    for (int i = 0; i < 32; i++) begin
      send(1'b0, 8'(i), i == 31);
      chk("t1_en",  32'(ifa.wr_en),  (i < 16) ? 32'd1 : 32'd2);
      chk("t1_adr", 32'(ifa.wr_adr), 32'(i % 16));
      chk("t1_dat", 32'(ifa.wr_dat), 32'(i));
    end
    @(posedge clk); #1;
    chk("t1_done", 32'(done_a),    32'd1);
    chk("t1_busy_end", 32'(busy_a), 32'd0);
    chk("t1_ovf",  32'(ovf_a),     32'd0);
    chk("t1_en_off", 32'(ifa.wr_en), 32'd0);

    // 33rd byte lands on the overflow limit.
    pulse_start(1'b0);
    chk("t2_done_clr", 32'(done_a), 32'd0);
    for (int i = 0; i <= 32; i++) begin
      send(1'b0, 8'(i), i == 32);
      chk("t2_en", 32'(ifa.wr_en), (i == 32) ? 32'd0 : ((i < 16) ? 32'd1 : 32'd2));
    end
    chk("t2_ovf",  32'(ovf_a),  32'd1);
    chk("t2_done", 32'(done_a), 32'd1);
    chk("t2_busy", 32'(busy_a), 32'd0);

    // 300 x 0xFF: 76500 mod 65536 = 0x2AD4.
    pulse_start(1'b0);
    chk("t3_ovf_clr", 32'(ovf_a), 32'd0);
    for (int i = 0; i < 300; i++) send(1'b0, 8'hFF, i == 299);
`ifdef DL_CSUM_EN
    csum_exp = 16'h2AD4;
`else
    csum_exp = 16'h0000;
`endif
    chk("t3_csum", 32'(csum_a), 32'(csum_exp));
    chk("t3_ovf",  32'(ovf_a),  32'd1);
    chk("t3_done", 32'(done_a), 32'd1);

    // WS=3 single byte.
    pulse_start(1'b1);
    send(1'b1, 8'hA5, 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk("t4_en",    32'(ifb.wr_en),   32'd1);
      chk("t4_dat",   32'(ifb.wr_dat),  32'hA5);
      chk("t4_ready", 32'(ifb.s_ready), 32'd0);
      chk("t4_done",  32'(done_b),      32'd0);
      @(posedge clk); #1;
    end
    chk("t4_en_off", 32'(ifb.wr_en), 32'd0);
    chk("t4_done_up", 32'(done_b),   32'd1);
    chk("t4_busy",   32'(busy_b),    32'd0);

    // Restart during HOLD of byte 5.
    pulse_start(1'b1);
    for (int i = 0; i < 6; i++) send(1'b1, 8'(8'h10 + i), 1'b0);
    chk("t5_adr5", 32'(ifb.wr_adr), 32'd5);
    @(posedge clk); #1;
    chk("t5_hold_en", 32'(ifb.wr_en), 32'd1);
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk); #1;
    chk("t5_en_drop", 32'(ifb.wr_en),   32'd0);
    chk("t5_ready",   32'(ifb.s_ready), 32'd1);
    chk("t5_busy",    32'(busy_b),      32'd1);
    @(negedge clk);
    start_b = 1'b0;
    send(1'b1, 8'h77, 1'b1);
    chk("t5_adr0", 32'(ifb.wr_adr), 32'd0);
    chk("t5_en0",  32'(ifb.wr_en),  32'd1);
    chk("t5_dat",  32'(ifb.wr_dat), 32'h77);

    // Asynchronous reset: A waiting in RECV with valid high, B mid-write.
    @(negedge clk);
    start_a = 1'b1;
    start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    drive(1'b1, 8'h44, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("t6_b_en", 32'(ifb.wr_en), 32'd1);
    drive(1'b1, 8'h00, 1'b0, 1'b0);
    chk("t6_a_ready_pre", 32'(ifa.s_ready), 32'd1);
    drive(1'b0, 8'h33, 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_a_ready", 32'(ifa.s_ready), 32'd0);
    chk("t6_a_busy",  32'(busy_a),      32'd0);
    chk("t6_b_en_off", 32'(ifb.wr_en),  32'd0);
    chk("t6_b_busy",  32'(busy_b),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("t6_idle_ready", 32'(ifa.s_ready), 32'd0);
      chk("t6_idle_en",    32'(ifa.wr_en),   32'd0);
      chk("t6_idle_busy",  32'(busy_a),      32'd0);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
